alu_issue_decoder: RTL and testbench
====================================

Name: alu_issue_decoder

Overview:
- Decode/issue stage that produces the ALU control and operand interface (operandA, operandB, funct3, funct7) from RV32I instruction words.
- Sits between instruction fetch and the ALU.
- Contains the 32x32 register file with a write-back port.
- Translates standard RV32I OP/OP-IMM encodings into the ALU's local funct3 code map.
- Registers each result behind a valid/ready handshake.

Parameters:
- XLEN, 32, data width of registers and operands; only 32 is supported.
- WB_BYPASS, 1, when 1 a same-cycle write-back to a source register is forwarded to the decoded operand.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  instruction word present
- in_ready  output  1  stage can accept an instruction this cycle
- in_instr  input  32  RV32I instruction word
- wb_en  input  1  register-file write enable
- wb_rd  input  5  write-back destination index
- wb_data  input  XLEN  write-back data
- out_valid  output  1  decoded bundle present
- out_ready  input  1  ALU/execute accepts the bundle
- out_operandA  output  XLEN  ALU operandA
- out_operandB  output  XLEN  ALU operandB (register or immediate)
- out_funct3  output  3  ALU-local op code
- out_funct7  output  1  ALU sub/arith-shift select
- out_rd  output  5  destination register
- out_we  output  1  result must be written back
- out_illegal  output  1  instruction not supported by the ALU

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- On rst:
  - out_valid=0.
  - out_operandA, out_operandB, out_funct3, out_funct7, out_rd, out_we and out_illegal all 0.
  - All 32 registers cleared to 0.
  - An in-flight bundle is discarded.
  - A wb_en asserted in the same cycle as rst is ignored.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and held 1 during rst.
  - A transfer occurs when in_valid && in_ready. The bundle appears on the output registers the next cycle with out_valid=1. Latency is 1 cycle.
  - When out_valid && !out_ready, all out_* hold stable and in_ready=0.
  - When out_ready=1 and no input transfer occurs, out_valid falls to 0 next cycle.
  - Full throughput: back-to-back transfers are possible with out_ready held at 1.
- Register file:
  - Reads are combinational on rs1=in_instr[19:15] and rs2=in_instr[24:20]. x0 always reads 0.
  - Writes occur on the clock edge when wb_en && wb_rd!=0. Writes to x0 are dropped.
  - Write-back is independent of the handshake and is accepted even when the stage is stalled.
  - With WB_BYPASS=1, wb_en && wb_rd==rs && rs!=0 forwards wb_data into the operand captured that cycle.
- ALU funct3 code map: 000 add/sub, 001 sll, 010 and, 011 or, 100 xor, 101 srl/sra.
- Standard-to-ALU funct3 translation: 000->000, 001->001, 100->100, 101->101, 110->011, 111->010. Standard 010 and 011 (slt/sltu) are illegal.
- OP (opcode 0110011):
  - operandA = x[rs1], operandB = x[rs2].
  - funct7 field 0000000 is legal for any mapped funct3 and gives out_funct7=0.
  - funct7 field 0100000 is legal only with funct3 000 or 101 and gives out_funct7=1.
  - Any other funct7 field is illegal.
- OP-IMM (opcode 0010011):
  - operandA = x[rs1].
  - Non-shift ops: operandB = sign-extended instr[31:20], out_funct7=0.
  - SLLI: operandB = {27'b0, instr[24:20]}. Requires instr[31:25]==0000000.
  - SRLI/SRAI: operandB = {27'b0, instr[24:20]}. instr[31:25] must be 0000000 (out_funct7=0) or 0100000 (out_funct7=1).
- Any other opcode is illegal.
- Illegal bundle:
  - Still handshaked, with out_illegal=1.
  - out_operandA, out_operandB, out_funct3 and out_funct7 are 0; out_we=0.
  - out_rd = instr[11:7].
- out_we = legal && rd!=0.
- Arithmetic: no width growth; all operands are exactly XLEN bits.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with x1=10, x2=20 preloaded via wb -> next cycle: out_valid=1, operandA=10, operandB=20, funct3=000, funct7=0, rd=3, we=1.
- SUB x3,x1,x2 (0x402081B3), then SRAI x4,x1,2 with x1=0xFFFFFFF0 -> SUB: funct3=000, funct7=1. SRAI: operandB=2, funct3=101, funct7=1.
- AND (std 111) and OR (std 110) on x1=0x15, x2=0x1B -> funct3 010 and 011 respectively. ADDI x5,x0,-1 -> operandB=0xFFFFFFFF, operandA=0.
- SLT (0x0020A1B3) -> out_illegal=1, we=0, operands 0. Opcode 0x03 (load) -> illegal. SUB encoding with funct3 100 -> illegal.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Release -> next instruction appears the following cycle with no loss or duplication.
- wb_en=1, wb_rd=1, wb_data=0x55 in the same cycle ADD x3,x1,x0 is accepted -> operandA=0x55. wb_rd=0 write followed by a read of x0 -> 0. rst mid-stall -> out_valid=0 next cycle and x1 reads 0.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// alu_issue_decoder
//   Decode/issue stage between instruction fetch and the ALU. Holds the
//   32-entry register file (with a write-back port), decodes RV32I OP and
//   OP-IMM words into the ALU's local funct3 map and presents one registered
//   operand bundle per accepted instruction behind a valid/ready handshake.
// ---------------------------------------------------------------------------
module alu_issue_decoder #(
    parameter int XLEN      = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_operandA,
    output logic [XLEN-1:0] out_operandB,
    output logic [2:0]      out_funct3,
    output logic            out_funct7,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    // Major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct7 patterns: base ops and the sub / arithmetic-shift variant
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Standard funct3 values that need special treatment
    localparam logic [2:0] STD_ADD = 3'b000;
    localparam logic [2:0] STD_SLL = 3'b001;
    localparam logic [2:0] STD_SR  = 3'b101;

    // Translate a standard RV32I funct3 into the ALU-local code.
    // Returns {supported, alu_code}; slt/sltu have no ALU code.
    function automatic logic [3:0] map_funct3(input logic [2:0] std_f3);
        logic [3:0] res;
        case (std_f3)
            3'b000:  res = {1'b1, 3'b000};
            3'b001:  res = {1'b1, 3'b001};
            3'b100:  res = {1'b1, 3'b100};
            3'b101:  res = {1'b1, 3'b101};
            3'b110:  res = {1'b1, 3'b011};
            3'b111:  res = {1'b1, 3'b010};
            default: res = {1'b0, 3'b000};
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] opcode_s;
    logic [4:0] rd_s;
    logic [2:0] funct3_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic [6:0] funct7_s;

    assign opcode_s = in_instr[6:0];
    assign rd_s     = in_instr[11:7];
    assign funct3_s = in_instr[14:12];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];
    assign funct7_s = in_instr[31:25];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_r [32];

    // Register file write port; x0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;

    // Source operand reads with optional same-cycle write-back forwarding
    always_comb begin
        rs1_val_s = '0;
        rs2_val_s = '0;

        if (rs1_s == 5'd0) begin
            rs1_val_s = '0;
        end else if (WB_BYPASS && wb_en && (wb_rd == rs1_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = regs_r[rs1_s];
        end

        if (rs2_s == 5'd0) begin
            rs2_val_s = '0;
        end else if (WB_BYPASS && wb_en && (wb_rd == rs2_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = regs_r[rs2_s];
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0]      map_s;
    logic            legal_s;
    logic [XLEN-1:0] dec_a_s;
    logic [XLEN-1:0] dec_b_s;
    logic [2:0]      dec_f3_s;
    logic            dec_f7_s;

    // Classify the instruction and pick operands / ALU controls
    always_comb begin
        map_s    = map_funct3(funct3_s);
        legal_s  = 1'b0;
        dec_a_s  = '0;
        dec_b_s  = '0;
        dec_f3_s = map_s[2:0];
        dec_f7_s = 1'b0;

        case (opcode_s)
            OPC_OP: begin
                dec_a_s = rs1_val_s;
                dec_b_s = rs2_val_s;
                if (funct7_s == F7_BASE) begin
                    legal_s  = map_s[3];
                    dec_f7_s = 1'b0;
                end else if (funct7_s == F7_ALT) begin
                    // Only sub and sra have an alternate form
                    legal_s  = (funct3_s == STD_ADD) || (funct3_s == STD_SR);
                    dec_f7_s = 1'b1;
                end else begin
                    legal_s  = 1'b0;
                    dec_f7_s = 1'b0;
                end
            end

            OPC_OP_IMM: begin
                dec_a_s = rs1_val_s;
                case (funct3_s)
                    STD_SLL: begin
                        dec_b_s  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                        legal_s  = (funct7_s == F7_BASE);
                        dec_f7_s = 1'b0;
                    end
                    STD_SR: begin
                        dec_b_s  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                        legal_s  = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
                        dec_f7_s = (funct7_s == F7_ALT);
                    end
                    default: begin
                        // Non-shift immediates: sign-extended 12-bit field
                        dec_b_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                        legal_s  = map_s[3];
                        dec_f7_s = 1'b0;
                    end
                endcase
            end

            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    logic [XLEN-1:0] nxt_a_s;
    logic [XLEN-1:0] nxt_b_s;
    logic [2:0]      nxt_f3_s;
    logic            nxt_f7_s;
    logic            nxt_we_s;

    // Illegal bundles carry zeroed ALU controls and never write back
    always_comb begin
        nxt_a_s  = '0;
        nxt_b_s  = '0;
        nxt_f3_s = 3'b000;
        nxt_f7_s = 1'b0;
        nxt_we_s = 1'b0;
        if (legal_s) begin
            nxt_a_s  = dec_a_s;
            nxt_b_s  = dec_b_s;
            nxt_f3_s = dec_f3_s;
            nxt_f7_s = dec_f7_s;
            nxt_we_s = (rd_s != 5'd0);
        end else begin
            nxt_a_s  = '0;
            nxt_b_s  = '0;
            nxt_f3_s = 3'b000;
            nxt_f7_s = 1'b0;
            nxt_we_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and output bundle
    // ------------------------------------------------------------------
    logic            out_valid_r;
    logic [XLEN-1:0] out_a_r;
    logic [XLEN-1:0] out_b_r;
    logic [2:0]      out_f3_r;
    logic            out_f7_r;
    logic [4:0]      out_rd_r;
    logic            out_we_r;
    logic            out_ill_r;
    logic            in_ready_s;
    logic            accept_s;

    // Ready whenever the output slot is empty or being drained; forced high in reset
    assign in_ready_s = rst || !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;

    // Output bundle register: load on accept, drop valid on drain, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_a_r     <= '0;
            out_b_r     <= '0;
            out_f3_r    <= 3'b000;
            out_f7_r    <= 1'b0;
            out_rd_r    <= 5'd0;
            out_we_r    <= 1'b0;
            out_ill_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_a_r     <= nxt_a_s;
            out_b_r     <= nxt_b_s;
            out_f3_r    <= nxt_f3_s;
            out_f7_r    <= nxt_f7_s;
            out_rd_r    <= rd_s;
            out_we_r    <= nxt_we_s;
            out_ill_r   <= !legal_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_operandA = out_a_r;
    assign out_operandB = out_b_r;
    assign out_funct3   = out_f3_r;
    assign out_funct7   = out_f7_r;
    assign out_rd       = out_rd_r;
    assign out_we       = out_we_r;
    assign out_illegal  = out_ill_r;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_decoder
//   Directed scenarios followed by randomized traffic, all checked against a
//   mnemonic-level reference model of the decode/issue stage.
// ---------------------------------------------------------------------------
module tb_alu_issue_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_operandA;
    logic [31:0] out_operandB;
    logic [2:0]  out_funct3;
    logic        out_funct7;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    alu_issue_decoder #(.XLEN(32), .WB_BYPASS(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_operandA(out_operandA),
        .out_operandB(out_operandB),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } bundle_t;

    logic [31:0] m_regs [32];
    logic        m_valid;
    bundle_t     m_out;

    // ALU code for each standard funct3; -1 means the ALU has no such op
    function automatic int alu_code(input logic [2:0] std);
        case (std)
            3'd0: return 0;   // add/sub
            3'd1: return 1;   // sll
            3'd4: return 4;   // xor
            3'd5: return 5;   // srl/sra
            3'd6: return 3;   // or
            3'd7: return 2;   // and
            default: return -1; // slt, sltu
        endcase
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] ins,
                                           input logic [31:0] xa,
                                           input logic [31:0] xb);
        bundle_t     r;
        bit          legal;
        int          code;
        logic [6:0]  f7;
        logic [2:0]  f3;
        r     = '0;
        legal = 1'b0;
        f7    = ins[31:25];
        f3    = ins[14:12];
        code  = alu_code(f3);
        if (ins[6:0] == 7'h33) begin
            r.a   = xa;
            r.b   = xb;
            r.f7  = (f7 == 7'h20);
            legal = (code >= 0) &&
                    ((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
        end else if (ins[6:0] == 7'h13) begin
            r.a = xa;
            if (f3 == 3'd1) begin
                r.b   = 32'(ins[24:20]);
                legal = (f7 == 7'h00);
            end else if (f3 == 3'd5) begin
                r.b   = 32'(ins[24:20]);
                r.f7  = (f7 == 7'h20);
                legal = (f7 == 7'h00) || (f7 == 7'h20);
            end else begin
                r.b   = 32'($signed(ins[31:20]));
                legal = (code >= 0);
            end
        end
        r.f3  = (code >= 0) ? code[2:0] : 3'd0;
        r.rd  = ins[11:7];
        r.ill = !legal;
        r.we  = legal && (ins[11:7] != 5'd0);
        if (!legal) begin
            r.a  = 32'd0;
            r.b  = 32'd0;
            r.f3 = 3'd0;
            r.f7 = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (!rst && wb_en && wb_rd == idx) return wb_data;
        return m_regs[idx];
    endfunction

    // One clock: check ready, advance model, check outputs after the edge
    task automatic step();
        bit      exp_ready;
        bit      xfer;
        bit      was_rst;
        bundle_t dec;
        #1;
        exp_ready = rst || !m_valid || out_ready;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        xfer    = in_valid && exp_ready && !rst;
        was_rst = rst;
        dec     = ref_decode(in_instr, rd_reg(in_instr[19:15]), rd_reg(in_instr[24:20]));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_out   = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (xfer) begin
                m_valid = 1'b1;
                m_out   = dec;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid || was_rst) begin
            check("operandA", out_operandA, m_out.a);
            check("operandB", out_operandB, m_out.b);
            check("funct3", 32'(out_funct3), 32'(m_out.f3));
            check("funct7", 32'(out_funct7), 32'(m_out.f7));
            check("rd", 32'(out_rd), 32'(m_out.rd));
            check("we", 32'(out_we), 32'(m_out.we));
            check("illegal", 32'(out_illegal), 32'(m_out.ill));
        end
    endtask

    // ---------------- encoders / generators ----------------
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [2:0] f3  = 3'($urandom_range(0, 7));
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        logic [4:0] rd  = 5'($urandom_range(0, 31));
        logic [6:0] f7a = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 6))
            0, 1:    return r_type(f7a, rs2, rs1, f3, rd);
            2:       return i_type(12'($urandom), rs1, f3, rd);
            3:       return i_type({f7a, rs2}, rs1, (($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5), rd);
            4:       return r_type(7'($urandom), rs2, rs1, f3, rd);
            5:       return {25'($urandom), 7'h13};
            default: return $urandom;
        endcase
    endfunction

    task automatic wb(input logic [4:0] idx, input logic [31:0] val);
        in_valid = 1'b0;
        wb_en    = 1'b1;
        wb_rd    = idx;
        wb_data  = val;
        step();
        wb_en    = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] add_x3_x1_x0;
        add_x3_x1_x0 = r_type(7'h00, 5'd0, 5'd1, 3'd0, 5'd3);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid   = 1'b0;
        m_out     = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        wb_en     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        out_ready = 1'b1;
        @(negedge clk);

        // Reset state
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // ADD x3,x1,x2
        wb(5'd1, 32'd10);
        wb(5'd2, 32'd20);
        issue(32'h002081B3);
        check("add_opA", out_operandA, 32'd10);
        check("add_opB", out_operandB, 32'd20);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_we", 32'(out_we), 32'd1);

        // SUB then SRAI
        wb(5'd1, 32'hFFFF_FFF0);
        issue(32'h402081B3);
        check("sub_f7", 32'(out_funct7), 32'd1);
        check("sub_f3", 32'(out_funct3), 32'd0);
        issue(i_type({7'h20, 5'd2}, 5'd1, 3'd5, 5'd4));
        check("srai_opB", out_operandB, 32'd2);
        check("srai_f3", 32'(out_funct3), 32'd5);
        check("srai_f7", 32'(out_funct7), 32'd1);

        // AND / OR / ADDI -1
        wb(5'd1, 32'h15);
        wb(5'd2, 32'h1B);
        issue(r_type(7'h00, 5'd2, 5'd1, 3'd7, 5'd3));
        check("and_f3", 32'(out_funct3), 32'd2);
        issue(r_type(7'h00, 5'd2, 5'd1, 3'd6, 5'd3));
        check("or_f3", 32'(out_funct3), 32'd3);
        issue(i_type(12'hFFF, 5'd0, 3'd0, 5'd5));
        check("addi_opB", out_operandB, 32'hFFFF_FFFF);
        check("addi_opA", out_operandA, 32'd0);

        // Illegal encodings
        issue(32'h0020A1B3);
        check("slt_ill", 32'(out_illegal), 32'd1);
        check("slt_we", 32'(out_we), 32'd0);
        check("slt_opA", out_operandA, 32'd0);
        issue(32'h0000A183);
        check("load_ill", 32'(out_illegal), 32'd1);
        issue(r_type(7'h20, 5'd2, 5'd1, 3'd4, 5'd3));
        check("subxor_ill", 32'(out_illegal), 32'd1);

        // Stall for 3 cycles, then release
        issue(add_x3_x1_x0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h402081B3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_opA", out_operandA, 32'h15);
            check("stall_f7", 32'(out_funct7), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("release_f7", 32'(out_funct7), 32'd1);
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Same-cycle write-back forwarding
        wb_en   = 1'b1;
        wb_rd   = 5'd1;
        wb_data = 32'h55;
        issue(add_x3_x1_x0);
        wb_en = 1'b0;
        check("bypass_opA", out_operandA, 32'h55);

        // x0 write dropped
        wb(5'd0, 32'hDEAD_BEEF);
        issue(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd3));
        check("x0_opA", out_operandA, 32'd0);

        // Reset in the middle of a stall
        issue(add_x3_x1_x0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("rst_stall_valid", 32'(out_valid), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        issue(add_x3_x1_x0);
        check("rst_x1_opA", out_operandA, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 1) == 0);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
